// File: rtl/axo_regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass,
// a pending-write scoreboard and a sequential clear engine.
module axo_regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    output logic                    ready,
    input  logic [NREAD*5-1:0]      rs,
    output logic [NREAD*XLEN-1:0]   dout,
    output logic [NREAD-1:0]        busy,
    input  logic [NWRITE*5-1:0]     rd,
    input  logic [NWRITE-1:0]       we,
    input  logic [NWRITE*XLEN-1:0]  din,
    input  logic                    claim_en,
    input  logic [4:0]              claim_rd
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   data_q [1:31];
    logic [XLEN-1:0]   data_d [1:31];
    logic [31:1]       pend_q, pend_d;
    logic              ready_q, ready_d;

    // Next-state: clear engine walks x1..x31, RUN applies writes then claims.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        pend_d  = pend_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q != 5'd0) begin
                    data_d[cnt_q] = {XLEN{1'b0}};
                end else begin
                    data_d = data_q;
                end
                if (cnt_q == 5'd31) begin
                    state_d = ST_RUN;
                    cnt_d   = 5'd1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_RUN: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = 5'd1;
                    pend_d  = '0;
                end else begin
                    // Ascending j so the highest write port wins on a collision.
                    for (int j = 0; j < NWRITE; j++) begin
                        if (we[j] && (rd[5*j +: 5] != 5'd0)) begin
                            data_d[rd[5*j +: 5]] = din[XLEN*j +: XLEN];
                            pend_d[rd[5*j +: 5]] = 1'b0;
                        end else begin
                            pend_d = pend_d;
                        end
                    end
                    // Claim is applied last so it beats a same-edge write.
                    if (claim_en && (claim_rd != 5'd0)) begin
                        pend_d[claim_rd] = 1'b1;
                    end else begin
                        pend_d = pend_d;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = 5'd1;
                pend_d  = '0;
            end
        endcase
        ready_d = (state_d == ST_RUN);
    end

    // State, scoreboard and storage registers; storage is zeroed by the engine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= 5'd1;
            pend_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    // Combinational read ports with optional same-cycle forwarding.
    always_comb begin
        dout = '0;
        busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            if ((state_q == ST_RUN) && (rs[5*i +: 5] != 5'd0)) begin
                dout[XLEN*i +: XLEN] = data_q[rs[5*i +: 5]];
                busy[i]              = pend_q[rs[5*i +: 5]];
                for (int j = 0; j < NWRITE; j++) begin
                    if ((BYPASS != 0) && we[j] && (rd[5*j +: 5] == rs[5*i +: 5])) begin
                        dout[XLEN*i +: XLEN] = din[XLEN*j +: XLEN];
                        busy[i]              = 1'b0;
                    end else begin
                        busy[i] = busy[i];
                    end
                end
            end else begin
                dout[XLEN*i +: XLEN] = {XLEN{1'b0}};
                busy[i]              = 1'b0;
            end
        end
    end

    assign ready = ready_q;

endmodule
